// File: rtl/alu_issue.sv
// alu_issue: decode/issue/writeback stage in front of a 4-bit-opcode ALU.
// Holds at most one instruction at a time. It reads operands from a local
// register file, feeds the external combinational ALU and runs the load/store
// memory handshake. The result is then written back to rd.
module alu_issue #(
    parameter int DATAWIDTH = 32,
    parameter int NUM_REGS  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [31:0]          instr_i,
    output logic [3:0]           alu_op_o,
    output logic [DATAWIDTH-1:0] alu_a_o,
    output logic [DATAWIDTH-1:0] alu_b_o,
    input  logic [DATAWIDTH-1:0] alu_result_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [DATAWIDTH-1:0] mem_addr_o,
    output logic [DATAWIDTH-1:0] mem_wdata_o,
    input  logic [DATAWIDTH-1:0] mem_rdata_i,
    input  logic                 mem_ack_i,
    output logic                 retire_o,
    output logic                 illegal_o,
    input  logic [4:0]           dbg_raddr_i,
    output logic [DATAWIDTH-1:0] dbg_rdata_o
);

    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_SW   = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_LAST = 4'd8;
    localparam logic [5:0] LP_NREGS = 6'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t               r_state;
    logic [31:0]          r_instr;
    logic [DATAWIDTH-1:0] r_rf [NUM_REGS];
    logic [DATAWIDTH-1:0] r_rs2;
    logic [DATAWIDTH-1:0] r_result;
    logic                 r_ready;
    logic [3:0]           r_alu_op;
    logic [DATAWIDTH-1:0] r_alu_a;
    logic [DATAWIDTH-1:0] r_alu_b;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [DATAWIDTH-1:0] r_mem_addr;
    logic [DATAWIDTH-1:0] r_mem_wdata;
    logic                 r_retire;
    logic                 r_illegal;

    logic [3:0]           w_op;
    logic [4:0]           w_rd;
    logic [4:0]           w_rs1;
    logic [4:0]           w_rs2;
    logic [DATAWIDTH-1:0] w_imm_sext;
    logic [DATAWIDTH-1:0] w_rs1_val;
    logic [DATAWIDTH-1:0] w_rs2_val;
    logic                 w_is_mem;
    logic                 w_rd_writable;
    logic                 w_sw_done;

    assign w_op       = r_instr[31:28];
    assign w_rd       = r_instr[27:23];
    assign w_rs1      = r_instr[22:18];
    assign w_rs2      = r_instr[17:13];
    assign w_imm_sext = {{(DATAWIDTH-13){r_instr[12]}}, r_instr[12:0]};
    assign w_is_mem   = (w_op == OP_LW) || (w_op == OP_SW);

    // r0 and indices beyond the file always read as zero
    assign w_rs1_val = (w_rs1 == 5'd0 || {1'b0, w_rs1} >= LP_NREGS) ? '0 : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0 || {1'b0, w_rs2} >= LP_NREGS) ? '0 : r_rf[w_rs2];
    assign dbg_rdata_o = (dbg_raddr_i == 5'd0 || {1'b0, dbg_raddr_i} >= LP_NREGS)
                         ? '0 : r_rf[dbg_raddr_i];
    assign w_rd_writable = (w_rd != 5'd0) && ({1'b0, w_rd} >= 6'd0) && ({1'b0, w_rd} < LP_NREGS);

    // A store retires in the same cycle its acknowledge arrives
    assign w_sw_done = (r_state == S_MEM) && r_mem_we && mem_ack_i;

    assign instr_ready_o = r_ready;
    assign alu_op_o      = r_alu_op;
    assign alu_a_o       = r_alu_a;
    assign alu_b_o       = r_alu_b;
    assign mem_req_o     = r_mem_req;
    assign mem_we_o      = r_mem_we;
    assign mem_addr_o    = r_mem_addr;
    assign mem_wdata_o   = r_mem_wdata;
    assign retire_o      = r_retire | w_sw_done;
    assign illegal_o     = r_illegal;

    // Issue FSM with registered outputs and register-file writeback
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_instr     <= '0;
            r_rs2       <= '0;
            r_result    <= '0;
            r_ready     <= 1'b1;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_retire    <= 1'b0;
            r_illegal   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_retire  <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid_i && r_ready) begin
                        r_instr <= instr_i;
                        r_ready <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_op > OP_LAST) begin
                        r_illegal <= 1'b1;
                        r_ready   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_alu_op <= w_op;
                        r_alu_a  <= w_rs1_val;
                        r_alu_b  <= w_is_mem ? w_imm_sext : w_rs2_val;
                        r_rs2    <= w_rs2_val;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_is_mem) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= (w_op == OP_SW);
                        r_mem_addr  <= alu_result_i;
                        r_mem_wdata <= r_rs2;
                        r_state     <= S_MEM;
                    end else begin
                        // Division by zero yields all-ones regardless of the ALU
                        r_result <= (w_op == OP_DIV && r_rs2 == '0) ? '1 : alu_result_i;
                        r_retire <= 1'b1;
                        r_state  <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                        if (r_mem_we) begin
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_result <= mem_rdata_i;
                            r_retire <= 1'b1;
                            r_state  <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (w_rd_writable) begin
                        r_rf[w_rd] <= r_result;
                    end
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus random instructions, with a
// reference register-file model, a behavioural ALU and a memory responder.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [31:0] instr_i = '0;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_a_o, alu_b_o, alu_result;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        retire_o, illegal_o;
    logic [4:0]  dbg_raddr_i = '0;
    logic [31:0] dbg_rdata_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int accept_cyc = 0;

    // expected completion events: 0 = register retire, 1 = store retire, 2 = illegal
    typedef struct { int kind; int lat; } sb_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } mem_t;
    sb_t  sbq[$];
    mem_t mq[$];

    logic [31:0] m [32];
    logic [31:0] next_rdata = '0;
    int          mem_delay = 0;
    bit          abort_mem = 1'b0;

    alu_issue #(.DATAWIDTH(32), .NUM_REGS(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_result_i(alu_result),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .retire_o(retire_o), .illegal_o(illegal_o),
        .dbg_raddr_i(dbg_raddr_i), .dbg_rdata_o(dbg_rdata_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU; division by zero returns junk the DUT must discard
    always_comb begin
        alu_result = '0;
        case (alu_op_o)
            4'd0, 4'd1, 4'd2: alu_result = alu_a_o + alu_b_o;
            4'd3: alu_result = alu_a_o - alu_b_o;
            4'd4: alu_result = alu_a_o * alu_b_o;
            4'd5: alu_result = (alu_b_o == 0) ? 32'h1234_5678 : alu_a_o / alu_b_o;
            4'd6: alu_result = alu_a_o & alu_b_o;
            4'd7: alu_result = alu_a_o | alu_b_o;
            4'd8: alu_result = alu_a_o ^ alu_b_o;
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports a completion
    always begin
        @(negedge clk);
        if (!rst_i && (retire_o || illegal_o)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_completion", {30'd0, illegal_o, retire_o}, 32'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("completion_kind", {30'd0, illegal_o, retire_o},
                    (e.kind == 2) ? 32'd2 : 32'd1);
                if (e.lat >= 0) chk("retire_latency", cyc + 1 - accept_cyc, e.lat);
            end
        end
    end

    // Memory responder: checks the request, waits, then pulses ack
    always begin
        @(posedge clk); #1;
        if (mem_req_o && !abort_mem) begin
            mem_t e;
            if (mq.size() == 0) begin
                chk("unexpected_mem_req", 32'd1, 32'd0);
            end else begin
                e = mq.pop_front();
                chk("mem_we", {31'd0, mem_we_o}, {31'd0, e.we});
                chk("mem_addr", mem_addr_o, e.addr);
                if (e.we) chk("mem_wdata", mem_wdata_o, e.wdata);
            end
            for (int k = 0; k < mem_delay; k++) begin
                @(posedge clk); #1;
                if (abort_mem) break;
                chk("mem_req_held", {31'd0, mem_req_o}, 32'd1);
            end
            if (!abort_mem) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = next_rdata;
                @(posedge clk); #1;
                mem_ack_i   = 1'b0;
                mem_rdata_i = '0;
            end
        end
    end

    task automatic dbg_chk(input int idx);
        @(negedge clk);
        dbg_raddr_i = 5'(idx);
        #1;
        chk($sformatf("dbg_r%0d", idx), dbg_rdata_o, m[idx]);
    endtask

    task automatic sweep();
        for (int i = 0; i < 32; i++) dbg_chk(i);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready_o) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one instruction: predict its outcome, drive it, wait for completion
    task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [12:0] imm,
                         input logic [31:0] rdata, input int dly);
        logic [31:0] a, b, addr, res;
        sb_t  e;
        mem_t me;
        a = m[rs1];
        b = m[rs2];
        addr = a + {{19{imm[12]}}, imm};
        res = '0;
        e.lat = -1;
        e.kind = 0;
        case (op)
            4'd0: res = a + b;
            4'd3: res = a - b;
            4'd4: res = a * b;
            4'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd6: res = a & b;
            4'd7: res = a | b;
            4'd8: res = a ^ b;
            4'd1: res = rdata;
            4'd2: e.kind = 1;
            default: e.kind = 2;
        endcase
        if (op != 4'd1 && op != 4'd2 && op <= 4'd8) e.lat = 3;
        if (op == 4'd1 || op == 4'd2) begin
            me.addr = addr; me.we = (op == 4'd2); me.wdata = b;
            mq.push_back(me);
        end
        if (e.kind == 0 && rd != 0) m[rd] = res;
        sbq.push_back(e);
        next_rdata = rdata;
        mem_delay  = dly;
        @(negedge clk);
        wait_ready();
        instr_valid_i = 1'b1;
        instr_i = {op, rd, rs1, rs2, imm};
        @(posedge clk); #1;
        accept_cyc = cyc;
        instr_valid_i = 1'b0;
        chk("ready_low_after_accept", {31'd0, instr_ready_o}, 32'd0);
        @(negedge clk);
        wait_ready();
        dbg_chk(int'(rd));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) m[i] = '0;
        // 1. reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        chk("rst_ready", {31'd0, instr_ready_o}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_retire", {31'd0, retire_o}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
        chk("rst_alu_a", alu_a_o, 32'd0);
        sweep();

        // 2. seed r1=7, r2=5, then sub r3 = r1 - r2
        issue(4'd0, 5'd1, 5'd0, 5'd0, 13'd0, 32'd0, 0);
        issue(4'd1, 5'd1, 5'd0, 5'd0, 13'd0, 32'd7, 1);
        issue(4'd1, 5'd2, 5'd0, 5'd0, 13'd0, 32'd5, 0);
        issue(4'd3, 5'd3, 5'd1, 5'd2, 13'd0, 32'd0, 0);
        chk("r3_value", m[3], 32'd2);

        // 3. lw r4,[r1-3] with a slow ack
        issue(4'd1, 5'd4, 5'd1, 5'd0, 13'h1FFD, 32'hDEAD_BEEF, 4);
        // 4. sw [r1+8] = r2
        issue(4'd2, 5'd0, 5'd1, 5'd2, 13'd8, 32'd0, 2);
        // 5. illegal opcode, write to r0, divide by zero
        issue(4'hC, 5'd3, 5'd1, 5'd2, 13'd0, 32'd0, 0);
        issue(4'd0, 5'd0, 5'd1, 5'd2, 13'd0, 32'd0, 0);
        issue(4'd5, 5'd5, 5'd1, 5'd0, 13'd0, 32'd0, 0);
        sweep();

        // random instruction mix
        for (int n = 0; n < 70; n++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            issue(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 13'($urandom), $urandom, $urandom_range(0, 3));
        end
        sweep();

        // 6. reset while a load waits for its acknowledge
        begin
            mem_t me;
            int n;
            me.addr = m[1]; me.we = 1'b0; me.wdata = '0;
            mq.push_back(me);
            mem_delay = 50;
            @(negedge clk);
            instr_valid_i = 1'b1;
            instr_i = {4'd1, 5'd6, 5'd1, 5'd0, 13'd0};
            @(negedge clk);
            instr_valid_i = 1'b0;
            n = 0;
            while (!mem_req_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("abort_req_seen", {31'd0, mem_req_o}, 32'd1);
            repeat (3) @(negedge clk);
            abort_mem = 1'b1;
            rst_i = 1'b1;
            @(posedge clk); #1;
            chk("abort_req_drop", {31'd0, mem_req_o}, 32'd0);
            chk("abort_ready", {31'd0, instr_ready_o}, 32'd1);
            @(negedge clk);
            rst_i = 1'b0;
            abort_mem = 1'b0;
            for (int i = 0; i < 32; i++) m[i] = '0;
            repeat (3) @(negedge clk);
            chk("abort_no_retire_pending", sbq.size(), 32'd0);
            sweep();
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 32'd0);
        chk("mq_drained", mq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
